// File: rtl/counter_sequencer_if.sv
// Control/config inputs and count/status outputs of the counter sequencer.
// master drives the controls and observes status; slave is the sequencer.
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_dir;
    logic             cfg_auto;
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             BUSY;
    logic             DONE;
    logic             CFG_ERR;

    modport master (
        output cfg_we, cfg_limit, cfg_dir, cfg_auto, start, pause, abort,
        input  Q, TC, BUSY, DONE, CFG_ERR
    );

    modport slave (
        input  cfg_we, cfg_limit, cfg_dir, cfg_auto, start, pause, abort,
        output Q, TC, BUSY, DONE, CFG_ERR
    );
endinterface

// File: rtl/counter_sequencer.sv
// Start/pause/abort sequencer for an up/down counter with programmable limit; all outputs registered,
// one edge from input to output. pause freezes the count; no other backpressure.
module counter_sequencer #(
    parameter int WIDTH         = 4,
    parameter int DEFAULT_LIMIT = 9
) (
    input  logic                CLK,
    input  logic                RST,
    counter_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    localparam logic [WIDTH-1:0] DEF_LIMIT = WIDTH'(DEFAULT_LIMIT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             auto_q, auto_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             terminal;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            limit_q <= DEF_LIMIT;
            dir_q   <= 1'b0;
            auto_q  <= 1'b0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            auto_q  <= auto_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        limit_d  = limit_q;
        dir_d    = dir_q;
        auto_d   = auto_q;
        tc_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        terminal = dir_q ? (q_q == '0) : (q_q == limit_q);

        if (bus.abort) begin
            state_d = S_IDLE;
            q_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            // Config writes while running are dropped but flagged; the run itself carries on.
            if (bus.cfg_we && (state_q == S_RUN || state_q == S_HOLD)) begin
                err_d = 1'b1;
            end
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.cfg_we) begin
                        limit_d = bus.cfg_limit;
                        dir_d   = bus.cfg_dir;
                        auto_d  = bus.cfg_auto;
                        err_d   = 1'b0;
                        q_d     = bus.cfg_dir ? bus.cfg_limit : '0;
                    end else if (bus.start) begin
                        q_d     = dir_q ? limit_q : '0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.pause) begin
                        state_d = S_HOLD;
                    end else if (!terminal) begin
                        q_d = dir_q ? q_q - 1'b1 : q_q + 1'b1;
                    end else if (auto_q) begin
                        q_d  = dir_q ? limit_q : '0;
                        tc_d = 1'b1;
                    end else begin
                        tc_d    = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
                S_HOLD: begin
                    if (!bus.pause) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.Q       = q_q;
    assign bus.TC      = tc_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.CFG_ERR = err_q;
endmodule
